iob_sp_rom_arb: RTL

Round-robin arbiter that shares one `iob_sp_rom` instance among `N_REQ` requesters. It accepts at most one read per cycle, drives the ROM `r_en`/`addr` for the winner, and returns the ROM data with a one-cycle-delayed per-requester valid strobe. It sits directly between the requesters and the ROM, and the ROM is instantiated outside it.

---
 rtl/iob_sp_rom_arb_pkg.sv | 16 +
 rtl/iob_rr_arb.sv | 58 +++++
 rtl/iob_sp_rom_arb.sv | 72 +++++++
 3 files changed

// File: rtl/iob_sp_rom_arb_pkg.sv
// iob_sp_rom_arb_pkg
//   Shared helpers for the ROM arbiter slice.
//   - clog2_min1(n): ceil(log2(n)), never less than 1, so a pointer or index
//     register always has at least one bit.
package iob_sp_rom_arb_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/iob_rr_arb.sv
// iob_rr_arb
//   Combinational round-robin arbiter with a registered priority pointer.
//   The winner is the first asserted request at ptr, ptr+1, ... (mod N_REQ).
//   On a grant to g, ptr moves to (g+1) mod N_REQ; otherwise it holds.
// Ports
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-high reset (clears ptr)
//   req_valid  in  N_REQ request bits
//   gnt        out N_REQ one-hot grant, all-zero when no request
module iob_rr_arb
  import iob_sp_rom_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] gnt
);

  localparam int PTR_W = clog2_min1(N_REQ);

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] gidx;
  logic             found;
  int               idx;

  // Scan from the pointer upwards; the first hit wins and stops the scan.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gidx     = idx[PTR_W-1:0];
      end
    end
  end

  // Explicit wrap so non-power-of-two N_REQ also rotates correctly.
  always_comb begin
    ptr_next = ptr_reg;
    if (found) begin
      ptr_next = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/iob_sp_rom_arb.sv
// iob_sp_rom_arb
//   Shares one single-port ROM (registered output, 1-cycle latency) among
//   N_REQ requesters. One read is accepted per cycle; the response strobe
//   for the accepted requester fires one cycle later alongside the ROM data.
// Ports
//   clk         in  system clock, rising edge
//   rst         in  asynchronous active-high reset
//   req_valid   in  N_REQ pending-read bits
//   req_addr    in  N_REQ*ADDR_W flattened addresses, slice i = [i*ADDR_W +: ADDR_W]
//   req_ready   out one-hot accept for this cycle (zero when idle)
//   rsp_valid   out per-requester strobe, one cycle after accept
//   rsp_data    out ROM data, valid while any rsp_valid bit is high
//   rom_r_en    out ROM read enable
//   rom_addr    out ROM address (winner's slice, 0 when idle)
//   rom_r_data  in  ROM registered read data
module iob_sp_rom_arb
  import iob_sp_rom_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rom_r_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_r_data
);

  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  gnt_q;
  logic [ADDR_W-1:0] masked_addr [N_REQ];

  iob_rr_arb #(
    .N_REQ(N_REQ)
  ) u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .gnt       (gnt)
  );

  // AND-OR address mux: the grant is one-hot, so at most one slice survives.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr_mask
    assign masked_addr[gi] = gnt[gi] ? req_addr[gi*ADDR_W +: ADDR_W] : '0;
  end

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rom_addr = rom_addr | masked_addr[i];
    end
  end

  assign req_ready = gnt;
  assign rom_r_en  = |req_valid;

  // Grant delayed by the ROM latency marks which requester owns rsp_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gnt_q <= '0;
    else     gnt_q <= gnt;
  end

  assign rsp_valid = gnt_q;
  assign rsp_data  = rom_r_data;

endmodule
